// File: rtl/wbm_mux.sv
// -----------------------------------------------------------------------------
// wbm_mux : N-master to 1 Wishbone multiplexer / arbiter
//
// Arbitrates between NUM_MASTERS Wishbone masters and forwards the winner's
// request to one shared downstream port. The winning request (we/sel/adr/dat)
// is latched at grant time and held for the whole transfer. A watchdog
// releases the port and returns an error to the granted master if the
// downstream side stays silent for TIMEOUT cycles.
//
// Parameters
//   NUM_MASTERS  number of requesting masters (2..8)
//   TIMEOUT      BUSY cycles without ack/err before a mux-generated error (>=2)
//
// Configuration macro
//   WBM_MUX_ROUND_ROBIN_EN  defined   : round-robin arbitration
//                           undefined : fixed priority, lowest index wins
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i       per-master cycle, strobe, write enable
//   m_sel_i/m_adr_i/m_dat_i      per-master byte select, address, write data
//   m_dat_o                      read data broadcast to all masters
//   m_ack_o/m_err_o              per-master acknowledge / error
//   s_cyc_o/s_stb_o/s_we_o       downstream cycle, strobe, write enable
//   s_sel_o/s_adr_o/s_dat_o      latched request of the granted master
//   s_dat_i/s_ack_i/s_err_i      downstream read data, acknowledge, error
//   grant_o                      one-hot grant, zero while idle
// -----------------------------------------------------------------------------
module wbm_mux #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 32
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,

    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [2*NUM_MASTERS-1:0]    m_sel_i,
    input  logic [32*NUM_MASTERS-1:0]   m_adr_i,
    input  logic [16*NUM_MASTERS-1:0]   m_dat_i,
    output logic [15:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,

    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [1:0]                  s_sel_o,
    output logic [31:0]                 s_adr_o,
    output logic [15:0]                 s_dat_o,
    input  logic [15:0]                 s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,

    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] tmo_q, tmo_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [1:0]             sel_q, sel_d;
    logic [31:0]            adr_q, adr_d;
    logic [15:0]            dat_q, dat_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   win_vld;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand;
    logic                   busy;
    logic                   abort;

    // Per-master views of the packed request buses
    logic [1:0]             sel_arr [NUM_MASTERS];
    logic [31:0]            adr_arr [NUM_MASTERS];
    logic [15:0]            dat_arr [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign sel_arr[g] = m_sel_i[2*g  +: 2];
        assign adr_arr[g] = m_adr_i[32*g +: 32];
        assign dat_arr[g] = m_dat_i[16*g +: 16];
    end

    assign req = m_cyc_i & m_stb_i;

`ifdef WBM_MUX_ROUND_ROBIN_EN
    // ptr_q holds the index the next search starts from, i.e. the last
    // granted index + 1, so a fresh reset starts the search at master 0.
    logic [IDX_W-1:0] ptr_q, ptr_d;
    int unsigned      rr_pos;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        rr_pos  = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            rr_pos = 32'(ptr_q) + i;
            if (rr_pos >= 32'(NUM_MASTERS)) begin
                rr_pos = rr_pos - 32'(NUM_MASTERS);
            end
            cand = IDX_W'(rr_pos);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = IDX_W'(i);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end
`endif

    assign busy  = (state_q == BUSY);
    // Granted master withdrew its cycle while the transfer is outstanding
    assign abort = |(grant_q & ~m_cyc_i);

    // Next-state and next-register values
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        tmo_d   = '0;
`ifdef WBM_MUX_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                grant_d = '0;
                cyc_d   = 1'b0;
                if (win_vld) begin
                    state_d = BUSY;
                    cyc_d   = 1'b1;
                    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                        grant_d[i] = (IDX_W'(i) == win_idx);
                    end
                    we_d  = m_we_i[win_idx];
                    sel_d = sel_arr[win_idx];
                    adr_d = adr_arr[win_idx];
                    dat_d = dat_arr[win_idx];
                    cnt_d = '0;
`ifdef WBM_MUX_ROUND_ROBIN_EN
                    ptr_d = (32'(win_idx) == 32'(NUM_MASTERS - 1)) ? '0
                                                                   : win_idx + 1'b1;
`endif
                end
            end
            BUSY: begin
                // Completion and abort outrank the watchdog, so an ack that
                // lands on the expiry edge never produces an error.
                if (s_ack_i || s_err_i || abort) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cyc_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cyc_d   = 1'b0;
                    tmo_d   = grant_q;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef WBM_MUX_ROUND_ROBIN_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign s_cyc_o = cyc_q;
    assign s_stb_o = cyc_q;
    assign s_we_o  = we_q;
    assign s_sel_o = sel_q;
    assign s_adr_o = adr_q;
    assign s_dat_o = dat_q;
    assign grant_o = grant_q;

    assign m_dat_o = s_dat_i;
    assign m_ack_o = grant_q & {NUM_MASTERS{s_ack_i & busy}};
    assign m_err_o = (grant_q & {NUM_MASTERS{s_err_i & busy}}) | tmo_q;

endmodule

// File: tb/tb_wbm_mux.sv
module tb_wbm_mux;

    localparam int NM  = 2;
    localparam int TMO = 8;
`ifdef WBM_MUX_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_ni;
    logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
    logic [2*NM-1:0]   m_sel_i;
    logic [32*NM-1:0]  m_adr_i;
    logic [16*NM-1:0]  m_dat_i;
    logic [15:0]       m_dat_o;
    logic [NM-1:0]     m_ack_o, m_err_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [1:0]        s_sel_o;
    logic [31:0]       s_adr_o;
    logic [15:0]       s_dat_o;
    logic [15:0]       s_dat_i;
    logic              s_ack_i, s_err_i;
    logic [NM-1:0]     grant_o;

    // per-master stimulus
    logic              cyc_v [2];
    logic              we_v  [2];
    logic [1:0]        sel_v [2];
    logic [31:0]       adr_v [2];
    logic [15:0]       dat_v [2];

    assign m_cyc_i = {cyc_v[1], cyc_v[0]};
    assign m_stb_i = {cyc_v[1], cyc_v[0]};
    assign m_we_i  = {we_v[1], we_v[0]};
    assign m_sel_i = {sel_v[1], sel_v[0]};
    assign m_adr_i = {adr_v[1], adr_v[0]};
    assign m_dat_i = {dat_v[1], dat_v[0]};

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic        we;
    } txn_t;

    txn_t sb[$];
    txn_t exp_t;
    int   n_tests = 0;
    int   n_fail  = 0;

    wbm_mux #(
        .NUM_MASTERS (NM),
        .TIMEOUT     (TMO)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_sel_i   (m_sel_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .grant_o   (grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge wb_clk_i);
    endtask

    task automatic set_req(input logic k, input logic on, input logic we,
                           input logic [1:0] sel, input logic [31:0] adr,
                           input logic [15:0] dat);
        cyc_v[k] = on;
        we_v[k]  = we;
        sel_v[k] = sel;
        adr_v[k] = adr;
        dat_v[k] = dat;
    endtask

    task automatic idle_all();
        set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0);
    endtask

    task automatic push_txn(input logic [1:0] g, input logic [31:0] a,
                            input logic [15:0] d, input logic [1:0] s, input logic w);
        txn_t t;
        t.gnt = g; t.adr = a; t.dat = d; t.sel = s; t.we = w;
        sb.push_back(t);
    endtask

    task automatic test_reset();
        wb_rst_ni = 1'b0;
        set_req(1'b0, 1'b1, 1'b1, 2'b11, 32'h1111_2222, 16'h3333);
        sample();
        n_tests++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %b want 0", s_cyc_o); end
        n_tests++; if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", s_stb_o); end
        n_tests++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        n_tests++; if (s_adr_o !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", s_adr_o); end
        n_tests++; if ({s_we_o, s_sel_o, s_dat_o} !== 19'h0) begin n_fail++; $display("FAIL reset_we_sel_dat: got %b %b %h want 0", s_we_o, s_sel_o, s_dat_o); end
        n_tests++; if ({m_ack_o, m_err_o} !== 4'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b %b want 0", m_ack_o, m_err_o); end
        // release with a request pending: arbitration on the first edge after
        wb_rst_ni = 1'b1;
        step();
        sample();
        n_tests++; if (s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL first_arb_cyc: got %b want 1", s_cyc_o); end
        n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL first_arb_grant: got %b want 01", grant_o); end
        s_ack_i = 1'b1;
        step();
        s_ack_i = 1'b0;
        idle_all();
        sample();
        n_tests++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL first_arb_release: got %b want 0", s_cyc_o); end
    endtask

    task automatic test_single_write();
        set_req(1'b0, 1'b1, 1'b1, 2'b11, 32'h0001_0004, 16'hBEEF);
        push_txn(2'b01, 32'h0001_0004, 16'hBEEF, 2'b11, 1'b1);
        step();
        sample();
        exp_t = sb[0];
        n_tests++; if ({s_cyc_o, s_stb_o} !== 2'b11) begin n_fail++; $display("FAIL wr_cyc_stb: got %b%b want 11", s_cyc_o, s_stb_o); end
        n_tests++; if (grant_o !== exp_t.gnt) begin n_fail++; $display("FAIL wr_grant: got %b want %b", grant_o, exp_t.gnt); end
        n_tests++; if (s_adr_o !== exp_t.adr) begin n_fail++; $display("FAIL wr_adr: got %h want %h", s_adr_o, exp_t.adr); end
        n_tests++; if ({s_we_o, s_sel_o, s_dat_o} !== {exp_t.we, exp_t.sel, exp_t.dat}) begin n_fail++; $display("FAIL wr_we_sel_dat: got %b %b %h want %b %b %h", s_we_o, s_sel_o, s_dat_o, exp_t.we, exp_t.sel, exp_t.dat); end
        n_tests++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL wr_early_ack: got %b want 00", m_ack_o); end
        // master changes its request mid-transfer; latched values must hold
        set_req(1'b0, 1'b1, 1'b0, 2'b00, 32'hDEAD_0000, 16'h1234);
        step();
        step();
        s_ack_i = 1'b1;
        sample();
        exp_t = sb.pop_front();
        n_tests++; if (m_ack_o !== exp_t.gnt) begin n_fail++; $display("FAIL wr_ack: got %b want %b", m_ack_o, exp_t.gnt); end
        n_tests++; if (m_err_o !== 2'b00) begin n_fail++; $display("FAIL wr_err: got %b want 00", m_err_o); end
        n_tests++; if ({s_adr_o, s_dat_o, s_we_o, s_sel_o} !== {exp_t.adr, exp_t.dat, exp_t.we, exp_t.sel}) begin n_fail++; $display("FAIL wr_hold: got %h %h %b %b want %h %h %b %b", s_adr_o, s_dat_o, s_we_o, s_sel_o, exp_t.adr, exp_t.dat, exp_t.we, exp_t.sel); end
        step();
        s_ack_i = 1'b0;
        idle_all();
        sample();
        n_tests++; if ({s_cyc_o, grant_o, m_ack_o} !== 5'b0) begin n_fail++; $display("FAIL wr_done: got cyc=%b grant=%b ack=%b want 0", s_cyc_o, grant_o, m_ack_o); end
    endtask

    task automatic test_read_error();
        set_req(1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_2000, 16'h0000);
        push_txn(2'b10, 32'h0000_2000, 16'h0000, 2'b01, 1'b0);
        step();
        sample();
        n_tests++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL rd_grant: got %b want 10", grant_o); end
        n_tests++; if ({s_we_o, s_sel_o} !== 3'b001) begin n_fail++; $display("FAIL rd_we_sel: got %b %b want 0 01", s_we_o, s_sel_o); end
        s_err_i = 1'b1;
        s_dat_i = 16'h5A5A;
        #1;
        exp_t = sb.pop_front();
        n_tests++; if (m_err_o !== exp_t.gnt) begin n_fail++; $display("FAIL rd_err: got %b want %b", m_err_o, exp_t.gnt); end
        n_tests++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL rd_ack: got %b want 00", m_ack_o); end
        n_tests++; if (m_dat_o !== 16'h5A5A) begin n_fail++; $display("FAIL rd_dat: got %h want 5a5a", m_dat_o); end
        step();
        s_err_i = 1'b0;
        idle_all();
        sample();
        n_tests++; if ({s_cyc_o, grant_o, m_err_o} !== 5'b0) begin n_fail++; $display("FAIL rd_done: got cyc=%b grant=%b err=%b want 0", s_cyc_o, grant_o, m_err_o); end
    endtask

    task automatic test_abort();
        set_req(1'b1, 1'b1, 1'b1, 2'b10, 32'h0000_3000, 16'hCAFE);
        step();
        sample();
        n_tests++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL ab_grant: got %b want 10", grant_o); end
        step();
        step();
        set_req(1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_3000, 16'hCAFE);
        sample();
        n_tests++; if (s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL ab_cyc_before_edge: got %b want 1", s_cyc_o); end
        n_tests++; if ({m_ack_o, m_err_o} !== 4'b0) begin n_fail++; $display("FAIL ab_resp_before: got %b %b want 0", m_ack_o, m_err_o); end
        step();
        s_ack_i = 1'b1;
        sample();
        n_tests++; if ({s_cyc_o, grant_o} !== 3'b0) begin n_fail++; $display("FAIL ab_release: got cyc=%b grant=%b want 0", s_cyc_o, grant_o); end
        n_tests++; if ({m_ack_o, m_err_o} !== 4'b0) begin n_fail++; $display("FAIL ab_late_ack: got %b %b want 0", m_ack_o, m_err_o); end
        step();
        s_ack_i = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        bit dropped;
        n = 0;
        dropped = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_4000, 16'h0000);
        push_txn(2'b01, 32'h0000_4000, 16'h0000, 2'b11, 1'b0);
        step();
        sample();
        n_tests++; if (s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL tmo_start: got %b want 1", s_cyc_o); end
        for (int c = 1; c <= 3*TMO; c++) begin
            step();
            sample();
            if (m_err_o !== 2'b00) begin
                n = c;
                break;
            end
            if (s_cyc_o !== 1'b1) dropped = 1'b1;
        end
        n_tests++; if (n !== TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d cycles (0 = none)", n, TMO); end
        n_tests++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL tmo_cyc_held: got early drop want none"); end
        exp_t = sb.pop_front();
        n_tests++; if (m_err_o !== exp_t.gnt) begin n_fail++; $display("FAIL tmo_err: got %b want %b", m_err_o, exp_t.gnt); end
        n_tests++; if ({s_cyc_o, grant_o, m_ack_o} !== 5'b0) begin n_fail++; $display("FAIL tmo_release: got cyc=%b grant=%b ack=%b want 0", s_cyc_o, grant_o, m_ack_o); end
        idle_all();
        step();
        sample();
        n_tests++; if ({m_err_o, s_cyc_o} !== 3'b0) begin n_fail++; $display("FAIL tmo_pulse_width: got err=%b cyc=%b want 0", m_err_o, s_cyc_o); end
    endtask

    task automatic test_ack_beats_timeout();
        set_req(1'b0, 1'b1, 1'b1, 2'b11, 32'h0000_5000, 16'h5555);
        push_txn(2'b01, 32'h0000_5000, 16'h5555, 2'b11, 1'b1);
        step();
        sample();
        for (int c = 1; c < TMO; c++) begin
            step();
            sample();
            n_tests++; if ({m_err_o, s_cyc_o} !== 3'b001) begin n_fail++; $display("FAIL abt_wait_%0d: got err=%b cyc=%b want 00 1", c, m_err_o, s_cyc_o); end
        end
        s_ack_i = 1'b1;
        #1;
        exp_t = sb.pop_front();
        n_tests++; if (m_ack_o !== exp_t.gnt) begin n_fail++; $display("FAIL abt_ack: got %b want %b", m_ack_o, exp_t.gnt); end
        step();
        s_ack_i = 1'b0;
        idle_all();
        sample();
        n_tests++; if ({m_err_o, s_cyc_o, grant_o} !== 5'b0) begin n_fail++; $display("FAIL abt_no_err: got err=%b cyc=%b grant=%b want 0", m_err_o, s_cyc_o, grant_o); end
    endtask

    task automatic test_async_reset();
        set_req(1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_6000, 16'h6666);
        step();
        sample();
        n_tests++; if ({s_cyc_o, grant_o} !== 3'b101) begin n_fail++; $display("FAIL ar_busy: got cyc=%b grant=%b want 1 01", s_cyc_o, grant_o); end
        #1;
        wb_rst_ni = 1'b0;
        s_ack_i   = 1'b1;
        #1;
        n_tests++; if ({s_cyc_o, s_stb_o, grant_o} !== 4'b0) begin n_fail++; $display("FAIL ar_drop: got cyc=%b stb=%b grant=%b want 0", s_cyc_o, s_stb_o, grant_o); end
        n_tests++; if ({m_ack_o, m_err_o} !== 4'b0) begin n_fail++; $display("FAIL ar_no_resp: got %b %b want 0", m_ack_o, m_err_o); end
        n_tests++; if (s_adr_o !== 32'h0) begin n_fail++; $display("FAIL ar_adr: got %h want 0", s_adr_o); end
        idle_all();
        s_ack_i = 1'b0;
        #1;
        wb_rst_ni = 1'b1;
    endtask

    task automatic test_back_to_back();
        int k;
        logic [1:0] g;
        set_req(1'b0, 1'b1, 1'b1, 2'b11, 32'hA000_0000, 16'hAAAA);
        set_req(1'b1, 1'b1, 1'b0, 2'b11, 32'hB000_0000, 16'hBBBB);
        for (int t = 0; t < 4; t++) begin
            g = (RR && (t % 2 == 1)) ? 2'b10 : 2'b01;
            push_txn(g, (g == 2'b10) ? 32'hB000_0000 : 32'hA000_0000,
                     (g == 2'b10) ? 16'hBBBB : 16'hAAAA, 2'b11, (g == 2'b01));
        end
        for (int t = 0; t < 4; t++) begin
            k = 0;
            do begin
                step();
                sample();
                k++;
            end while (!s_cyc_o && k < 8);
            n_tests++; if (s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL b2b_wait_%0d: no grant within %0d cycles", t, k); end
            exp_t = sb.pop_front();
            n_tests++; if (grant_o !== exp_t.gnt) begin n_fail++; $display("FAIL b2b_grant_%0d: got %b want %b", t, grant_o, exp_t.gnt); end
            n_tests++; if ({s_adr_o, s_dat_o, s_we_o} !== {exp_t.adr, exp_t.dat, exp_t.we}) begin n_fail++; $display("FAIL b2b_req_%0d: got %h %h %b want %h %h %b", t, s_adr_o, s_dat_o, s_we_o, exp_t.adr, exp_t.dat, exp_t.we); end
            s_ack_i = 1'b1;
            #1;
            n_tests++; if (m_ack_o !== exp_t.gnt) begin n_fail++; $display("FAIL b2b_ack_%0d: got %b want %b", t, m_ack_o, exp_t.gnt); end
            step();
            s_ack_i = 1'b0;
            sample();
            n_tests++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap_%0d: got %b want 0", t, s_cyc_o); end
        end
        idle_all();
        n_tests++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        s_ack_i   = 1'b0;
        s_err_i   = 1'b0;
        s_dat_i   = 16'h0000;
        idle_all();
        test_reset();
        test_single_write();
        test_read_error();
        test_abort();
        test_timeout();
        test_ack_beats_timeout();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
